mult_share_arbiter: RTL and testbench
=====================================

// Module: mult_share_arbiter
// PURPOSE
//  - Shares one pipelined WIDTH x WIDTH parallel_multiplier among NUM_REQ requesters
//    (NTT/key-switch lanes of the HE datapath).
//  - Round-robin arbitration, one issue per cycle. Tags each issue with its requester
//    id and walks the tag down a MULT_LAT-deep shadow pipe, so each product returns
//    with the correct id.
//  - halt/drain FSM stops issue and signals when the multiplier pipe is empty
//    (e.g. before modulus/config change).
// PARAMETERS
//  WIDTH     64  operand width; product is 2*WIDTH
//  NUM_REQ   4   number of requesters (>=2)
//  MULT_LAT  2   clock edges from mul_x/mul_y presented to mul_prod valid (>=1)
//  ID_W      $clog2(NUM_REQ)  requester id width (derived, not overridable)
// PORTS
//  clk        in   1              clock, all state on rising edge
//  rst_n      in   1              async active-low reset
//  req_valid  in   NUM_REQ        per-requester operand valid
//  req_ready  out  NUM_REQ        per-requester accept (one-hot or zero)
//  req_x      in   NUM_REQ*WIDTH  packed multiplicands, requester i at [i*WIDTH +: WIDTH]
//  req_y      in   NUM_REQ*WIDTH  packed multipliers, same packing
//  mul_x      out  WIDTH          to multiplier x
//  mul_y      out  WIDTH          to multiplier y
//  mul_prod   in   2*WIDTH        from multiplier prod
//  rsp_valid  out  1              result valid (no backpressure; sink must accept)
//  rsp_id     out  ID_W           requester that owns rsp_prod
//  rsp_prod   out  2*WIDTH        product; zero when rsp_valid=0
//  halt_req   in   1              request issue stop + drain
//  halted     out  1              multiplier pipe empty, issue stopped
//  inflight   out  ID_W+2         ops issued but not yet returned (0..MULT_LAT)
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - req_ready=0, rsp_valid=0, rsp_id=0, rsp_prod=0, mul_x=mul_y=0, halted=0, inflight=0.
//    - rr_ptr=0, tag pipe cleared, FSM=RUN.
//    - Reset mid-operation drops all in-flight results; no rsp_valid until new issues.
//  - Arbitration (combinational, RUN state only):
//    - Winner is the first i with req_valid[i]=1, scanning from rr_ptr upward mod NUM_REQ.
//    - req_ready[winner]=1, all other bits 0. No winner -> req_ready=0.
//    - req_ready never depends on halt_req in the same cycle: it is gated by state, so a
//      cycle with halt_req=1 in RUN still issues.
//  - Issue:
//    - An issue occurs when req_valid[w]&req_ready[w].
//    - mul_x/mul_y = req_x/req_y slice of w; otherwise 0.
//    - On the edge: tag[0] <= {1,w}; rr_ptr <= (w+1) mod NUM_REQ.
//    - rr_ptr holds when there is no issue.
//  - Tag pipe:
//    - tag[k] <= tag[k-1] each edge; tag[0] <= {0,0} on non-issue cycles.
//    - rsp_valid = tag[MULT_LAT-1].v; rsp_id = tag[MULT_LAT-1].id.
//    - rsp_prod = rsp_valid ? mul_prod : 0.
//    - Latency: issue in cycle N -> rsp_valid in cycle N+MULT_LAT. Throughput 1/cycle.
//  - inflight = count of valid tags; +1 on issue, -1 on rsp_valid.
//    - Simultaneous issue+return leaves it unchanged; never exceeds MULT_LAT.
//  - FSM:
//    - RUN: issue allowed; halt_req=1 -> DRAIN.
//    - DRAIN: req_ready=0; next inflight==0 (i.e. tag pipe empty after edge) -> HALTED;
//      responses still delivered.
//    - HALTED: halted=1, req_ready=0; halt_req=0 -> RUN (issue resumes next cycle,
//      rr_ptr preserved).
//    - halt_req dropped during DRAIN: still completes to HALTED first, then returns to RUN.
//  - Requester may drop req_valid without handshake; no state is kept for it.
//  - Arithmetic is unsigned; full 2*WIDTH product, no truncation.
// TESTING
//  1. req_valid=0001, x=0x349, y=0x123 for 1 cycle -> rsp_valid exactly MULT_LAT cycles
//     later, rsp_id=0, rsp_prod=0x3BBFB; inflight 1 then 0.
//  2. req 2: x=0, y=0x0123456789ABCDEF -> rsp_id=2, rsp_prod=0.
//     Then x=0x123456789ABCDEF0, y=0x2349082309482384 -> rsp_prod == x*y (128-bit SV *).
//  3. All 4 valid continuously 8 cycles -> grants 0,1,2,3,0,1,2,3; back-to-back rsp_valid;
//     ids in same order; every product == x*y.
//  4. req 1,3 valid, rr_ptr=2 -> grant 3 then 1.
//     Requester 3 drops valid after grant -> next grant 1 only, no spurious rsp.
//  5. Continuous traffic, assert halt_req for 1 cycle -> that cycle issues; req_ready=0
//     after; MULT_LAT pending rsps delivered.
//     - halted=1 once inflight hits 0; halt_req=0 -> RUN, grant resumes at saved rr_ptr.
//  6. rst_n low with inflight=2 -> no rsp_valid thereafter; all outputs at reset values;
//     first grant after release goes to lowest valid index.

Source files
------------

// File: rtl/mult_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// mult_share_arbiter_if
// Bundles every handshake/bus signal of the shared-multiplier arbiter.
//   req_valid/req_ready/req_x/req_y : requester side (packed, WIDTH per lane)
//   mul_x/mul_y/mul_prod            : connection to the pipelined multiplier
//   rsp_valid/rsp_id/rsp_prod       : tagged product return (no backpressure)
//   halt_req/halted/inflight        : issue-stop / drain control and status
// Modports:
//   master : the arbiter itself
//   slave  : requesters, multiplier and controller surrounding the arbiter
// ---------------------------------------------------------------------------
interface mult_share_arbiter_if #(
  parameter int WIDTH   = 64,
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_x;
  logic [NUM_REQ*WIDTH-1:0] req_y;
  logic [WIDTH-1:0]         mul_x;
  logic [WIDTH-1:0]         mul_y;
  logic [2*WIDTH-1:0]       mul_prod;
  logic                     rsp_valid;
  logic [ID_W-1:0]          rsp_id;
  logic [2*WIDTH-1:0]       rsp_prod;
  logic                     halt_req;
  logic                     halted;
  logic [ID_W+1:0]          inflight;

  modport master (
    input  req_valid, req_x, req_y, mul_prod, halt_req,
    output req_ready, mul_x, mul_y, rsp_valid, rsp_id, rsp_prod, halted, inflight
  );

  modport slave (
    output req_valid, req_x, req_y, mul_prod, halt_req,
    input  req_ready, mul_x, mul_y, rsp_valid, rsp_id, rsp_prod, halted, inflight
  );
endinterface

// File: rtl/mult_share_arbiter.sv
// ---------------------------------------------------------------------------
// mult_share_arbiter
// Shares one pipelined WIDTH x WIDTH multiplier among NUM_REQ requesters.
// A round-robin arbiter issues at most one operand pair per cycle, and a
// MULT_LAT-deep tag pipe shadows the multiplier so each product comes back
// labelled with the requester that issued it. A halt/drain FSM stops issue
// and reports when the multiplier pipe is empty.
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mult_share_arbiter_if.master (requests, multiplier, responses,
//           halt control and status; see interface header)
// ---------------------------------------------------------------------------
module mult_share_arbiter #(
  parameter int WIDTH    = 64,
  parameter int NUM_REQ  = 4,
  parameter int MULT_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mult_share_arbiter_if.master bus
);
  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = ID_W + 2;

  localparam logic [ID_W:0]   NUM_REQ_W = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  state_e             state_r;
  state_e             state_nxt_s;
  logic [ID_W-1:0]    rr_ptr_r;
  logic [ID_W-1:0]    rr_ptr_nxt_s;
  logic [MULT_LAT-1:0] tag_v_r;
  logic [ID_W-1:0]    tag_id_r [MULT_LAT];
  logic [CNT_W-1:0]   inflight_r;
  logic [CNT_W-1:0]   inflight_nxt_s;

  logic               issue_en_s;
  logic               found_s;
  logic [ID_W-1:0]    win_s;
  logic               issue_s;
  logic               rsp_v_s;

  // Issue is gated by state only (never by halt_req directly). Also held off
  // while rst_n is low so nothing is accepted during an asynchronous reset.
  assign issue_en_s = (state_r == ST_RUN) && rst_n;
  assign rsp_v_s    = tag_v_r[MULT_LAT-1];

  // Round-robin search: first valid requester scanning upward from rr_ptr.
  always_comb begin
    logic [ID_W:0]   sum;
    logic [ID_W-1:0] idx;
    found_s = 1'b0;
    win_s   = '0;
    sum     = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_r} + (ID_W+1)'(k);
      if (sum >= NUM_REQ_W) begin
        idx = ID_W'(sum - NUM_REQ_W);
      end else begin
        idx = ID_W'(sum);
      end
      if (!found_s && bus.req_valid[idx]) begin
        found_s = 1'b1;
        win_s   = idx;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Grant, operand mux toward the multiplier, and round-robin pointer update.
  always_comb begin
    bus.req_ready = '0;
    bus.mul_x     = '0;
    bus.mul_y     = '0;
    issue_s       = 1'b0;
    rr_ptr_nxt_s  = rr_ptr_r;
    if (issue_en_s && found_s) begin
      issue_s                = 1'b1;
      bus.req_ready[win_s]   = 1'b1;
      bus.mul_x              = bus.req_x[int'(win_s)*WIDTH +: WIDTH];
      bus.mul_y              = bus.req_y[int'(win_s)*WIDTH +: WIDTH];
      if (win_s == LAST_ID) begin
        rr_ptr_nxt_s = '0;
      end else begin
        rr_ptr_nxt_s = win_s + ID_W'(1);
      end
    end else begin
      issue_s = 1'b0;
    end
  end

  // In-flight count: issue adds one, a tag leaving the last stage removes one.
  always_comb begin
    inflight_nxt_s = inflight_r;
    case ({issue_s, rsp_v_s})
      2'b10:   inflight_nxt_s = inflight_r + CNT_W'(1);
      2'b01:   inflight_nxt_s = inflight_r - CNT_W'(1);
      default: inflight_nxt_s = inflight_r;
    endcase
  end

  // Halt/drain FSM next state. DRAIN always completes to HALTED, even if
  // halt_req drops meanwhile; HALTED is left only once halt_req is low.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (bus.halt_req) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (inflight_nxt_s == '0) begin
          state_nxt_s = ST_HALTED;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_HALTED: begin
        if (!bus.halt_req) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_HALTED;
        end
      end
      default: state_nxt_s = ST_RUN;
    endcase
  end

  // FSM state, round-robin pointer and in-flight counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_RUN;
      rr_ptr_r   <= '0;
      inflight_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      rr_ptr_r   <= rr_ptr_nxt_s;
      inflight_r <= inflight_nxt_s;
    end
  end

  // Tag shadow pipe: walks {valid, id} alongside the multiplier stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v_r <= '0;
      for (int k = 0; k < MULT_LAT; k++) begin
        tag_id_r[k] <= '0;
      end
    end else begin
      tag_v_r[0]  <= issue_s;
      tag_id_r[0] <= issue_s ? win_s : '0;
      for (int k = 1; k < MULT_LAT; k++) begin
        tag_v_r[k]  <= tag_v_r[k-1];
        tag_id_r[k] <= tag_id_r[k-1];
      end
    end
  end

  // Response and status outputs, all derived from registered state.
  assign bus.rsp_valid = rsp_v_s;
  assign bus.rsp_id    = tag_id_r[MULT_LAT-1];
  assign bus.rsp_prod  = rsp_v_s ? bus.mul_prod : '0;
  assign bus.halted    = (state_r == ST_HALTED);
  assign bus.inflight  = inflight_r;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mult_share_arbiter
// Directed bench for mult_share_arbiter (WIDTH=64, NUM_REQ=4, MULT_LAT=2).
// A two-stage multiplier sits on the mul_x/mul_y/mul_prod port. Inputs are
// driven 1 time unit after each rising edge, outputs are checked on the
// falling edge.
// ---------------------------------------------------------------------------
module tb_mult_share_arbiter;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [63:0]  tx [4];
  logic [63:0]  ty [4];
  logic [127:0] p1;
  logic [127:0] p2;

  mult_share_arbiter_if #(.WIDTH(64), .NUM_REQ(4)) bus ();

  mult_share_arbiter #(.WIDTH(64), .NUM_REQ(4), .MULT_LAT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External pipelined multiplier, two edges of latency.
  always_ff @(posedge clk) begin
    p1 <= {64'd0, bus.mul_x} * {64'd0, bus.mul_y};
    p2 <= p1;
  end
  assign bus.mul_prod = p2;

  function automatic logic [127:0] mulw(input logic [63:0] a, input logic [63:0] b);
    return {64'd0, a} * {64'd0, b};
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic set_xy(input int i, input logic [63:0] xv, input logic [63:0] yv);
    bus.req_x[i*64 +: 64] = xv;
    bus.req_y[i*64 +: 64] = yv;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"},    bus.req_ready, 4'b0000);
    chk({tag, "_mulx"},     bus.mul_x, 64'd0);
    chk({tag, "_muly"},     bus.mul_y, 64'd0);
    chk({tag, "_rspv"},     bus.rsp_valid, 1'b0);
    chk({tag, "_rspid"},    bus.rsp_id, 2'd0);
    chk({tag, "_rspprod"},  bus.rsp_prod, 128'd0);
    chk({tag, "_halted"},   bus.halted, 1'b0);
    chk({tag, "_inflight"}, bus.inflight, 4'd0);
  endtask

  task automatic chk_rsp(input string tag, input logic [1:0] id, input logic [127:0] prod);
    chk({tag, "_rspv"},    bus.rsp_valid, 1'b1);
    chk({tag, "_rspid"},   bus.rsp_id, id);
    chk({tag, "_rspprod"}, bus.rsp_prod, prod);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.req_valid = 4'b0000;
    bus.req_x     = '0;
    bus.req_y     = '0;
    bus.halt_req  = 1'b0;
    tx[0] = 64'hFEDC_BA98_7654_3210; ty[0] = 64'h0000_0000_0000_0003;
    tx[1] = 64'hFFFF_FFFF_FFFF_FFFF; ty[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    tx[2] = 64'h0000_0001_0000_0001; ty[2] = 64'h8000_0000_0000_0000;
    tx[3] = 64'h1234_5678_9ABC_DEF0; ty[3] = 64'h0000_0000_0001_0000;

    // Reset state
    repeat (2) @(posedge clk);
    settle();
    chk_reset_outs("rst");
    rst_n = 1'b1;

    // Test 1: single issue from requester 0, latency and inflight
    tick(); set_xy(0, 64'h349, 64'h123); bus.req_valid = 4'b0001; settle();
    chk("t1_ready", bus.req_ready, 4'b0001);
    chk("t1_mulx", bus.mul_x, 64'h349);
    chk("t1_muly", bus.mul_y, 64'h123);
    chk("t1_infl0", bus.inflight, 4'd0);
    tick(); bus.req_valid = 4'b0000; settle();
    chk("t1_ready_off", bus.req_ready, 4'b0000);
    chk("t1_mulx_off", bus.mul_x, 64'd0);
    chk("t1_rspv_early", bus.rsp_valid, 1'b0);
    chk("t1_infl1", bus.inflight, 4'd1);
    tick(); settle();
    chk_rsp("t1", 2'd0, 128'h3BBFB);
    chk("t1_infl1b", bus.inflight, 4'd1);
    tick(); settle();
    chk("t1_rspv_end", bus.rsp_valid, 1'b0);
    chk("t1_prod_zero", bus.rsp_prod, 128'd0);
    chk("t1_infl_end", bus.inflight, 4'd0);

    // Test 2: requester 2, zero product then a full 128-bit product
    tick(); set_xy(2, 64'd0, 64'h0123_4567_89AB_CDEF); bus.req_valid = 4'b0100; settle();
    chk("t2_ready_a", bus.req_ready, 4'b0100);
    tick(); set_xy(2, 64'h1234_5678_9ABC_DEF0, 64'h2349_0823_0948_2384); settle();
    chk("t2_ready_b", bus.req_ready, 4'b0100);
    chk("t2_muly_b", bus.mul_y, 64'h2349_0823_0948_2384);
    tick(); bus.req_valid = 4'b0000; settle();
    chk_rsp("t2_a", 2'd2, 128'd0);
    tick(); settle();
    chk_rsp("t2_b", 2'd2, mulw(64'h1234_5678_9ABC_DEF0, 64'h2349_0823_0948_2384));

    // Requester 3 alone, so the pointer wraps back to 0
    tick(); set_xy(3, 64'd5, 64'd7); bus.req_valid = 4'b1000; settle();
    chk("t2_ready_c", bus.req_ready, 4'b1000);
    chk("t2_rspv_gap", bus.rsp_valid, 1'b0);
    tick(); bus.req_valid = 4'b0000; settle();
    tick(); settle();
    chk_rsp("t2_c", 2'd3, 128'h23);
    tick(); settle();
    chk("t2_rspv_end", bus.rsp_valid, 1'b0);

    // Test 3: all four requesting for 8 cycles
    for (int i = 0; i < 4; i++) set_xy(i, tx[i], ty[i]);
    for (int k = 0; k < 10; k++) begin
      tick();
      bus.req_valid = (k < 8) ? 4'b1111 : 4'b0000;
      settle();
      if (k < 8) chk($sformatf("t3_ready_%0d", k), bus.req_ready, 4'b0001 << (k % 4));
      if (k >= 2) chk_rsp($sformatf("t3_%0d", k), 2'((k - 2) % 4),
                          mulw(tx[(k - 2) % 4], ty[(k - 2) % 4]));
    end
    tick(); settle();
    chk("t3_rspv_end", bus.rsp_valid, 1'b0);
    chk("t3_infl_end", bus.inflight, 4'd0);

    // Test 4: requesters 1 and 3 with rr_ptr at 2; 3 drops after its grant
    set_xy(1, 64'h10, 64'h20);
    set_xy(3, 64'h3, 64'h300);
    tick(); bus.req_valid = 4'b0010; settle();
    chk("t4_ready_pre", bus.req_ready, 4'b0010);
    tick(); bus.req_valid = 4'b1010; settle();
    chk("t4_ready_3", bus.req_ready, 4'b1000);
    tick(); bus.req_valid = 4'b0010; settle();
    chk("t4_ready_1", bus.req_ready, 4'b0010);
    chk_rsp("t4_a", 2'd1, 128'h200);
    tick(); bus.req_valid = 4'b0000; settle();
    chk("t4_ready_none", bus.req_ready, 4'b0000);
    chk_rsp("t4_b", 2'd3, 128'h900);
    tick(); settle();
    chk_rsp("t4_c", 2'd1, 128'h200);
    tick(); settle();
    chk("t4_rspv_end", bus.rsp_valid, 1'b0);
    chk("t4_infl_end", bus.inflight, 4'd0);

    // Test 5: halt under continuous traffic
    for (int i = 0; i < 4; i++) set_xy(i, tx[i], ty[i]);
    tick(); bus.req_valid = 4'b1111; settle();
    chk("t5_ready_2", bus.req_ready, 4'b0100);
    chk("t5_halted_run", bus.halted, 1'b0);
    tick(); settle();
    chk("t5_ready_3", bus.req_ready, 4'b1000);
    tick(); bus.halt_req = 1'b1; settle();
    chk("t5_ready_halt_cycle", bus.req_ready, 4'b0001);
    chk_rsp("t5_a", 2'd2, mulw(tx[2], ty[2]));
    tick(); bus.halt_req = 1'b0; settle();
    chk("t5_ready_drain", bus.req_ready, 4'b0000);
    chk("t5_mulx_drain", bus.mul_x, 64'd0);
    chk("t5_infl_drain", bus.inflight, 4'd2);
    chk("t5_halted_drain", bus.halted, 1'b0);
    chk_rsp("t5_b", 2'd3, mulw(tx[3], ty[3]));
    tick(); settle();
    chk("t5_ready_drain2", bus.req_ready, 4'b0000);
    chk("t5_infl_drain2", bus.inflight, 4'd1);
    chk_rsp("t5_c", 2'd0, mulw(tx[0], ty[0]));
    tick(); settle();
    chk("t5_halted", bus.halted, 1'b1);
    chk("t5_infl_zero", bus.inflight, 4'd0);
    chk("t5_rspv_halted", bus.rsp_valid, 1'b0);
    chk("t5_ready_halted", bus.req_ready, 4'b0000);
    tick(); settle();
    chk("t5_halted_off", bus.halted, 1'b0);
    chk("t5_ready_resume", bus.req_ready, 4'b0010);

    // Test 6: reset with two operations in flight
    tick(); settle();
    chk("t6_ready_2", bus.req_ready, 4'b0100);
    chk("t6_rspv_gap", bus.rsp_valid, 1'b0);
    tick(); bus.req_valid = 4'b1010; settle();
    chk("t6_ready_3", bus.req_ready, 4'b1000);
    chk("t6_infl2", bus.inflight, 4'd2);
    chk_rsp("t6_pre", 2'd1, mulw(tx[1], ty[1]));
    rst_n = 1'b0;
    #1;
    chk_reset_outs("t6_inrst");
    repeat (2) @(posedge clk);
    settle();
    chk_reset_outs("t6_held");
    rst_n = 1'b1;
    #1;
    chk("t6_first_grant", bus.req_ready, 4'b0010);
    tick(); bus.req_valid = 4'b0000; settle();
    chk("t6_rspv_none", bus.rsp_valid, 1'b0);
    chk("t6_infl_new", bus.inflight, 4'd1);
    tick(); settle();
    chk_rsp("t6_new", 2'd1, mulw(tx[1], ty[1]));
    tick(); settle();
    chk("t6_rspv_end", bus.rsp_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
